// File: rtl/msrv32_seq_alu.sv
// msrv32 multi-cycle execute unit: 1-cycle RV32I ALU plus optional iterative RV32M
// (shift-add multiply, restoring divide) enabled by `define MSRV32_SEQ_ALU_MDU_EN.
module msrv32_seq_alu #(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [3:0]      opcode_in,
  input  logic            m_ext_in,
  input  logic            kill_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic            ready_q, valid_q;
  logic [XLEN-1:0] result_q;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  assign shamt = op_2_in[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode_in)
      4'b0000: alu_res = op_1_in + op_2_in;
      4'b1000: alu_res = op_1_in - op_2_in;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, op_1_in < op_2_in};
      4'b0111: alu_res = op_1_in & op_2_in;
      4'b0110: alu_res = op_1_in | op_2_in;
      4'b0100: alu_res = op_1_in ^ op_2_in;
      4'b0001: alu_res = op_1_in << shamt;
      4'b0101: alu_res = op_1_in >> shamt;
      4'b1101: alu_res = $signed(op_1_in) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef MSRV32_SEQ_ALU_MDU_EN
  // acc_q/lo_q/dvs_q are shared: {hi,lo} product + multiplicand for MUL*,
  // remainder/quotient + divisor for DIV*/REM*.
  logic [2:0]      mop_q;
  logic            neg_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] acc_q, lo_q, dvs_q;

  logic            a_sgn, b_sgn, neg_d, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (opcode_in[2:0])
      3'b001, 3'b100, 3'b110: begin
        a_sgn = op_1_in[XLEN-1];
        b_sgn = op_2_in[XLEN-1];
      end
      3'b010:  a_sgn = op_1_in[XLEN-1];
      default: ;
    endcase
    a_mag    = a_sgn ? -op_1_in : op_1_in;
    b_mag    = b_sgn ? -op_2_in : op_2_in;
    neg_d    = (opcode_in[2] & opcode_in[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = opcode_in[2] & (op_2_in == '0);
    div_ovf  = opcode_in[2] & ~opcode_in[0] & (&op_2_in) &
               (op_1_in == {1'b1, {(XLEN-1){1'b0}}});
    if (div_zero) spec_res = opcode_in[1] ? op_1_in : '1;
    else          spec_res = opcode_in[1] ? '0 : op_1_in;
  end

  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n, div_val, fin_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (mop_q[2]) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    div_val  = mop_q[1] ? hi_n : lo_n;
    if (mop_q[2])             fin_res = neg_q ? -div_val : div_val;
    else if (mop_q[1:0] == 0) fin_res = prod_fix[XLEN-1:0];
    else                      fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  assign busy_out = (state_q == CALC);
`else
  assign busy_out = 1'b0;
`endif

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
`ifdef MSRV32_SEQ_ALU_MDU_EN
      mop_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
`endif
    end else if (kill_in) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          ready_q <= 1'b0;
`ifdef MSRV32_SEQ_ALU_MDU_EN
          if (m_ext_in && !div_zero && !div_ovf) begin
            state_q <= CALC;
            cnt_q   <= SHW'(XLEN-1);
            mop_q   <= opcode_in[2:0];
            neg_q   <= neg_d;
            acc_q   <= '0;
            lo_q    <= a_mag;
            dvs_q   <= b_mag;
          end else if (m_ext_in) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= spec_res;
          end else
`endif
          begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= m_ext_in ? '0 : alu_res;
          end
        end
`ifdef MSRV32_SEQ_ALU_MDU_EN
        CALC: begin
          acc_q <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= fin_res;
          end
        end
`endif
        DONE: if (ready_in) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out  = ready_q;
  assign valid_out  = valid_q;
  assign result_out = result_q;

endmodule
